wb_result_select: RTL
=====================

# wb_result_select

Parametrised writeback result selector for the multicycle/pipelined core. It replaces the fixed 4-way combinational result mux with an N-source registered selector. The selector adds load-data byte/halfword extraction with sign/zero extension, alignment and select-range checking, and a 2-entry elastic buffer with valid/ready handshakes. It sits between the execute/memory stage (sources: ALUOut, ReadData, ALUResult, ImmExt, PC+4, …) and the register-file write port.

## Interface
- WIDTH, 32, datapath width; must be ≥ 32
- NSRC, 5, number of result sources; must be ≥ 2
- LOAD_SRC, 1, index of the source that receives load formatting (memory read data)
- SELW, $clog2(NSRC), localparam select width; not overridable

- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  upstream has a result to write back
- in_ready  output  1  buffer can accept; equals (count < 2)
- src_data  input  NSRC*WIDTH  packed sources; source i at [i*WIDTH +: WIDTH]
- result_src  input  SELW  source select
- load_fmt  input  3  funct3 encoding: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; others illegal
- byte_off  input  2  load address bits [1:0]
- rd_in  input  5  destination register
- we_in  input  1  register write request
- out_valid  output  1  head entry valid; equals (count != 0)
- out_ready  input  1  downstream (register file) accepts
- result  output  WIDTH  selected/formatted result of head entry
- rd_out  output  5  head entry destination
- we_out  output  1  head entry write enable, already qualified
- err  output  1  head entry flagged illegal

## Operation
- Transfers: push = in_valid & in_ready; pop = out_valid & out_ready.
- On push, the formatted entry {result, rd, we, err} is computed combinationally from the inputs and written to the tail.
- Selection:
  - result_src < NSRC and ≠ LOAD_SRC: value = src_data[result_src], unmodified.
  - result_src ≥ NSRC: value = 0, err = 1.
- Load formatting (result_src == LOAD_SRC); w = low 32 bits of the source:
  - LB/LBU: byte w[8*byte_off +: 8], sign/zero-extended to WIDTH.
  - LH/LHU: half w[16*byte_off[1] +: 16], extended to WIDTH; byte_off[0]=1 → err = 1, value = 0.
  - LW: w zero-extended to WIDTH; byte_off ≠ 0 → err = 1, value = 0.
  - Illegal load_fmt → err = 1, value = 0.
- load_fmt and byte_off are ignored for non-load sources.
- Write enable: we stored = we_in & (rd_in ≠ 0) & ~err. Writes to x0 are always suppressed; err is still reported.
- Buffer: 2 entries, head/tail pointer bits plus 2-bit count (0..2).
  - Push only: count+1.
  - Pop only: count−1.
  - Push and pop together: count unchanged; the new entry lands behind the remaining one, or becomes head if count was 1.
  - Pointers wrap modulo 2.
- Full (count = 2): in_ready = 0; in_valid is ignored and inputs may change freely.
- Empty (count = 0): out_valid = 0. result/rd_out/we_out/err hold the last popped entry's values, or 0 after reset.
- Head outputs are stable while out_valid & ~out_ready (no change until pop).
- Ordering: strict FIFO; no bypass from input to output.

## Timing
- Latency 1 cycle: an entry pushed at edge k is on the outputs with out_valid = 1 after edge k, if the buffer was empty.
- Throughput 1 entry/cycle when out_ready is held high.
- in_ready depends only on registered count; no combinational path from out_ready.
- Reset (rst_n low, any time, asynchronous):
  - count, pointers, out_valid, result, rd_out, we_out and err → 0; in_ready → 1.
  - In-flight entries are discarded.
- First push is possible at the first rising edge after rst_n deasserts.

## Test plan
- Basic select (NSRC=5): src i = 0x1000_0000+i, result_src=3, rd=7, we=1, out_ready=1 → one cycle later result=0x1000_0003, rd_out=7, we_out=1, err=0.
- Load extension: LOAD_SRC word 0x80F1_7F22:
  - LB off=1 → 0x0000_007F.
  - LB off=3 → 0xFFFF_FF80.
  - LBU off=2 → 0x0000_00F1.
  - LH off=2 → 0xFFFF_80F1.
  - LHU off=2 → 0x0000_80F1.
- Errors:
  - LW off=2 → err=1, result=0, we_out=0.
  - result_src=6 (with SELW=3) → err=1, result=0.
  - load_fmt=011 → err=1.
  - rd=0 with we=1 → we_out=0, err=0.
- Backpressure: out_ready=0 and push 3 values back-to-back → in_ready drops after the 2nd push and the 3rd is not accepted. Raise out_ready → entries 1 then 2 emerge in order, held stable while stalled.
- Simultaneous push/pop at count=1 for 10 cycles → count stays 1, outputs follow input order, no drops or duplicates.
- Reset mid-operation: buffer full, assert rst_n=0 between edges → immediately out_valid=0, result=0, in_ready=1. After release, a new push appears after 1 cycle.

Source files
------------

// File: rtl/wb_result_select_if.sv
// wb_result_select_if
// Bundles the upstream (execute/memory -> selector) and downstream
// (selector -> register file) signals of the writeback result selector.
//   Upstream:   in_valid, in_ready, src_data, result_src, load_fmt,
//               byte_off, rd_in, we_in
//   Downstream: out_valid, out_ready, result, rd_out, we_out, err
// Handshake rule on both sides: a beat transfers on a rising clock edge
// where valid and ready are both high. The sender holds its valid and
// payload stable until that edge. Ready never depends combinationally on
// the valid it is paired with.
// modport slave  : the selector itself.
// modport master : the environment (stage pipeline and register file).
interface wb_result_select_if #(
   parameter int WIDTH = 32,
   parameter int NSRC  = 5
);
   localparam int SELW = (NSRC > 1) ? $clog2(NSRC) : 1;

   logic                    in_valid;
   logic                    in_ready;
   logic [NSRC*WIDTH-1:0]   src_data;
   logic [SELW-1:0]         result_src;
   logic [2:0]              load_fmt;
   logic [1:0]              byte_off;
   logic [4:0]              rd_in;
   logic                    we_in;
   logic                    out_valid;
   logic                    out_ready;
   logic [WIDTH-1:0]        result;
   logic [4:0]              rd_out;
   logic                    we_out;
   logic                    err;

   modport slave (
      input  in_valid, src_data, result_src, load_fmt, byte_off, rd_in, we_in,
      input  out_ready,
      output in_ready, out_valid, result, rd_out, we_out, err
   );

   modport master (
      output in_valid, src_data, result_src, load_fmt, byte_off, rd_in, we_in,
      output out_ready,
      input  in_ready, out_valid, result, rd_out, we_out, err
   );
endinterface

// File: rtl/wb_result_select.sv
// wb_result_select
// N-source registered writeback result selector. Picks one of NSRC
// sources, applies RISC-V load byte/halfword extraction with sign/zero
// extension to the LOAD_SRC source, flags illegal selects/formats/
// misalignment, qualifies the write enable, and queues the formatted
// entry in a 2-entry FIFO toward the register file write port.
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - wb_result_select_if.slave (upstream + downstream handshakes)
module wb_result_select #(
   parameter int WIDTH    = 32,
   parameter int NSRC     = 5,
   parameter int LOAD_SRC = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   wb_result_select_if.slave   bus
);
   typedef struct packed {
      logic [WIDTH-1:0] result;
      logic [4:0]       rd;
      logic             we;
      logic             err;
   } entry_t;

   // Formatting of the incoming entry
   logic [WIDTH-1:0] sel_word;
   logic [31:0]      load_word;
   logic [7:0]       byte_v;
   logic [15:0]      half_v;
   logic [WIDTH-1:0] fmt_val;
   logic             fmt_err;
   entry_t           new_entry;

   always_comb begin
      sel_word  = '0;
      load_word = bus.src_data[LOAD_SRC*WIDTH +: 32];
      fmt_val   = '0;
      fmt_err   = 1'b0;
      for (int i = 0; i < NSRC; i++) begin
         if (int'(bus.result_src) == i) sel_word = bus.src_data[i*WIDTH +: WIDTH];
      end
      case (bus.byte_off)
         2'd0:    byte_v = load_word[7:0];
         2'd1:    byte_v = load_word[15:8];
         2'd2:    byte_v = load_word[23:16];
         default: byte_v = load_word[31:24];
      endcase
      half_v = bus.byte_off[1] ? load_word[31:16] : load_word[15:0];

      if (int'(bus.result_src) >= NSRC) begin
         fmt_err = 1'b1;
      end else if (int'(bus.result_src) == LOAD_SRC) begin
         case (bus.load_fmt)
            3'b000: fmt_val = WIDTH'($signed(byte_v));
            3'b100: fmt_val = WIDTH'(byte_v);
            3'b001: if (bus.byte_off[0]) fmt_err = 1'b1;
                    else fmt_val = WIDTH'($signed(half_v));
            3'b101: if (bus.byte_off[0]) fmt_err = 1'b1;
                    else fmt_val = WIDTH'(half_v);
            3'b010: if (bus.byte_off != 2'd0) fmt_err = 1'b1;
                    else fmt_val = WIDTH'(load_word);
            default: fmt_err = 1'b1;
         endcase
      end else begin
         fmt_val = sel_word;
      end

      new_entry.result = fmt_val;
      new_entry.rd     = bus.rd_in;
      // x0 writes are dropped even when the entry is otherwise legal
      new_entry.we     = bus.we_in & (bus.rd_in != 5'd0) & ~fmt_err;
      new_entry.err    = fmt_err;
   end

   // 2-entry FIFO
   entry_t     mem_q [2];
   entry_t     last_q;          // last popped entry, shown while empty
   logic       head_q, head_d;
   logic       tail_q, tail_d;
   logic [1:0] count_q, count_d;
   logic       push, pop;
   entry_t     head_entry;

   assign bus.in_ready  = (count_q != 2'd2);
   assign bus.out_valid = (count_q != 2'd0);
   assign push = bus.in_valid & bus.in_ready;
   assign pop  = bus.out_valid & bus.out_ready;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (push) tail_d = ~tail_q;
      if (pop)  head_d = ~head_q;
      if (push && !pop)      count_d = count_q + 2'd1;
      else if (pop && !push) count_d = count_q - 2'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q  <= 1'b0;
         tail_q  <= 1'b0;
         count_q <= 2'd0;
         last_q  <= '0;
         for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         if (push) mem_q[tail_q] <= new_entry;
         if (pop)  last_q <= mem_q[head_q];
      end
   end

   assign head_entry  = bus.out_valid ? mem_q[head_q] : last_q;
   assign bus.result  = head_entry.result;
   assign bus.rd_out  = head_entry.rd;
   assign bus.we_out  = head_entry.we;
   assign bus.err     = head_entry.err;
endmodule
